// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit (ops, FSM states, counter width).
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation: used for operand magnitudes and result sign fix-up.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    logic signed [WIDTH-1:0] in_s;

    assign in_s = in;
    assign out  = neg ? -in_s : in_s;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN skips the iteration phase for trivially-zero results.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_q, neg_r;

    logic               accept, op_sgn, op_div, sa, sb, skip;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign accept = start && (state == S_IDLE);
    assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
    assign op_div = (op == OP_DIV) || (op == OP_DIVU);
    assign sa     = op_sgn && A[WIDTH-1];
    assign sb     = op_sgn && B[WIDTH-1];

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (.in(A), .neg(sa), .out(mag_a));
    cond_negate #(.WIDTH(WIDTH)) u_abs_b (.in(B), .neg(sb), .out(mag_b));

`ifdef MULDIV_EARLY_OUT_EN
    assign skip = op_div ? ((A == '0) && (B != '0)) : ((A == '0) || (B == '0));
`else
    assign skip = 1'b0;
`endif

    // Unsigned magnitude core: shift-add multiply, restoring divide (acc = {rem, quotient})
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_nx, div_nx;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_nx    = {mul_sum, acc[WIDTH-1:1]};
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_nx    = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.in(acc), .neg(neg_q), .out(prod));
    cond_negate #(.WIDTH(WIDTH)) u_fix_quo (.in(acc[WIDTH-1:0]), .neg(neg_q), .out(quo));
    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (.in(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .out(rem));

    // Divide-by-zero leaves |A| in the remainder, so only the quotient needs forcing
    assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? (dz ? '1 : quo) : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = skip ? S_FIX : S_CALC;
            S_CALC:  if (cnt == '0) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
            dz   <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= (state == S_FIX);
            if (accept) begin
                cnt <= CNT_W'(WIDTH - 1);
                dz  <= op_div && (B == '0);
            end else if (state == S_CALC) begin
                cnt <= cnt - 1'b1;
            end
            if (state == S_FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if ((state == S_IDLE) && !start) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opnd   <= op_div ? mag_b : mag_a;
            acc    <= skip ? '0 : {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
            is_div <= op_div;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
        end else if (state == S_CALC) begin
            acc <= is_div ? div_nx : mul_nx;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] A, B, wdata;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] m_hi, m_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        rdz = 1'b0;
        rh  = '0;
        rl  = '0;
        sa  = a;
        sb  = b;
        case (o)
            2'b00: begin p = longint'(sa) * longint'(sb); {rh, rl} = p; end
            2'b01: begin pu = {32'b0, a} * {32'b0, b}; {rh, rl} = pu; end
            default: begin
                if (b == 0) begin
                    rl = '1; rh = a; rdz = 1'b1;
                end else if (o == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        rl = 32'h8000_0000; rh = '0;
                    end else begin
                        rl = sa / sb; rh = sa % sb;
                    end
                end else begin
                    rl = a / b; rh = a % b;
                end
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (o[1] ? (a == 0 && b != 0) : (a == 0 || b == 0)) lat = 2;
`endif
        return lat;
    endfunction

    // Called and returns at 1 time unit after a rising edge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit interfere, input bit wr_with_start, input string tag);
        logic [W-1:0] eh, el;
        logic         edz;
        int           n, lat;
        model(o, a, b, eh, el, edz);
        lat   = exp_latency(o, a, b);
        op    = o; A = a; B = b; start = 1'b1;
        if (wr_with_start) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                check({tag, "_busy_rise"}, busy, 1'b1);
                check({tag, "_dz_accept"}, dz, edz);
                if (wr_with_start) check({tag, "_start_wins_hi"}, hi, m_hi);
            end
            if (interfere && n == 10) begin
                start = 1'b1; op = 2'b10; A = $urandom; B = $urandom;
                hi_we = 1'b1; wdata = 32'h1234;
            end
            if (interfere && n == 11) begin
                start = 1'b0; hi_we = 1'b0;
                check({tag, "_hi_hold_busy"}, hi, m_hi);
                check({tag, "_lo_hold_busy"}, lo, m_lo);
            end
        end while (!done && n < 100);
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_dz"}, dz, edz);
        m_hi = eh;
        m_lo = el;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [W-1:0] d, input string tag);
        hi_we = h; lo_we = l; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int           sel, n;

        rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; A = '0; B = '0; wdata = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {busy, done, dz}, 3'b000);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max_lo_const", lo, 32'h0000_0001);
        run_op(2'b00, -32'sd3, 32'd7, 0, 0, "mult_neg");
        check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
        run_op(2'b10, -32'sd7, 32'd2, 0, 0, "div_neg");
        check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd0, 0, 0, "divu_zero");
        check("divu_zero_dz_const", dz, 1'b1);
        run_op(2'b01, 32'd6, 32'd9, 0, 0, "multu_clr_dz");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'd0, 0, 0, "div_min_zero");
        run_op(2'b00, 32'd0, 32'd5, 0, 0, "mult_zero");
        run_op(2'b11, 32'd0, 32'd9, 0, 0, "divu_a_zero");
        run_op(2'b01, 32'h0001_2345, 32'h0006_7890, 1, 0, "busy_ignore");
        run_op(2'b10, -32'sd100, -32'sd7, 0, 1, "start_wins");
        mt_write(1'b1, 1'b0, 32'hCAFE_0001, "mthi");
        mt_write(1'b0, 1'b1, 32'hCAFE_0002, "mtlo");

        for (int i = 0; i < 30; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) ra = '0;
            if (sel == 1) rb = '0;
            if (sel == 2) rb = 32'hFFFF_FFFF;
            if (sel == 3) ra = 32'h8000_0000;
            if (sel == 4) rb = 32'($urandom_range(1, 15));
            run_op(ro, ra, rb, 0, 0, "rand");
        end

        // Asynchronous reset in the middle of CALC
        op = 2'b01; A = $urandom; B = $urandom; start = 1'b1;
        n = 0;
        repeat (15) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("mid_busy_before_rst", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {busy, done, dz}, 3'b000);
        check("mid_rst_hi", hi, 32'h0);
        check("mid_rst_lo", lo, 32'h0);
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", busy, 1'b0);
        mt_write(1'b0, 1'b1, 32'h55, "mtlo_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
